axi_traffic_gen: RTL and testbench

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

---
 rtl/axi_traffic_gen.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator: NUM INCR bursts of patterned data, then reads them
// back, counting response, RLAST and (with TGEN_CHECK_EN defined) read-data errors.
module axi_traffic_gen #(
    parameter int unsigned WIDTH_AD  = 32,
    parameter int unsigned WIDTH_DA  = 32,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  START,
    input  logic [WIDTH_AD-1:0]   ADDR,
    input  logic [15:0]           NUM,
    input  logic [31:0]           SEED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           ERR_CNT,
    output logic [WIDTH_AD-1:0]   AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [WIDTH_DA-1:0]   WDATA,
    output logic [WIDTH_DA/8-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [WIDTH_AD-1:0]   ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [WIDTH_DA-1:0]   RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int unsigned BEAT_BYTES  = WIDTH_DA / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned REPL        = WIDTH_DA / 32;
    localparam logic [7:0]  LEN_M1      = 8'(BURST_LEN - 1);
    localparam logic [2:0]  SIZE        = 3'($clog2(BEAT_BYTES));
    localparam logic [WIDTH_AD-1:0] BURST_INC = WIDTH_AD'(BURST_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StFin
    } state_e;

    function automatic logic [WIDTH_AD-1:0] beat_addr(input logic [WIDTH_AD-1:0] base,
                                                      input logic [7:0] beat);
        return base + WIDTH_AD'(32'(beat) * BEAT_BYTES);
    endfunction

    // Low 32 bits of the beat byte address XOR seed, replicated across the bus.
    function automatic logic [WIDTH_DA-1:0] pattern(input logic [WIDTH_AD-1:0] a,
                                                    input logic [31:0] s);
        logic [31:0] a32;
        a32 = 32'(a);
        return {REPL{a32 ^ s}};
    endfunction

    state_e                state_q, state_d;
    logic [WIDTH_AD-1:0]   base_q, base_d;
    logic [WIDTH_AD-1:0]   cur_q, cur_d;
    logic [15:0]           num_q, num_d;
    logic [31:0]           seed_q, seed_d;
    logic [15:0]           bcnt_q, bcnt_d;
    logic [7:0]            beat_q, beat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           err_q, err_d;
    logic [WIDTH_AD-1:0]   awaddr_q, awaddr_d;
    logic [WIDTH_AD-1:0]   araddr_q, araddr_d;
    logic [WIDTH_DA-1:0]   wdata_q, wdata_d;
    logic                  wlast_q, wlast_d;
    logic [7:0]            axlen_q, axlen_d;
    logic [2:0]            axsize_q, axsize_d;
    logic [1:0]            axburst_q, axburst_d;
    logic                  err_hit;
    logic                  rd_mismatch;

`ifdef TGEN_CHECK_EN
    logic [WIDTH_DA-1:0] rd_expect;
    assign rd_expect   = pattern(beat_addr(cur_q, beat_q), seed_q);
    assign rd_mismatch = (RDATA != rd_expect);
`else
    logic unused_rdata;
    assign unused_rdata = ^RDATA;
    assign rd_mismatch  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cur_d     = cur_q;
        num_d     = num_q;
        seed_d    = seed_q;
        bcnt_d    = bcnt_q;
        beat_d    = beat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wlast_d   = wlast_q;
        axlen_d   = axlen_q;
        axsize_d  = axsize_q;
        axburst_d = axburst_q;
        err_hit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    base_d    = ADDR;
                    cur_d     = ADDR;
                    num_d     = NUM;
                    seed_d    = SEED;
                    bcnt_d    = 16'd0;
                    done_d    = 1'b0;
                    err_d     = 16'd0;
                    busy_d    = 1'b1;
                    awaddr_d  = ADDR;
                    axlen_d   = LEN_M1;
                    axsize_d  = SIZE;
                    axburst_d = 2'b01;
                    state_d   = (NUM == 16'd0) ? StFin : StWrAddr;
                end
            end
            StWrAddr: begin
                if (AWREADY) begin
                    beat_d  = 8'd0;
                    wdata_d = pattern(cur_q, seed_q);
                    wlast_d = (LEN_M1 == 8'd0);
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (WREADY) begin
                    if (beat_q == LEN_M1) begin
                        state_d = StWrResp;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wdata_d = pattern(beat_addr(cur_q, beat_q + 8'd1), seed_q);
                        wlast_d = ((beat_q + 8'd1) == LEN_M1);
                    end
                end
            end
            StWrResp: begin
                if (BVALID) begin
                    err_hit = (BRESP != 2'b00);
                    bcnt_d  = bcnt_q + 16'd1;
                    if ((bcnt_q + 16'd1) == num_q) begin
                        // Writes complete: rewind to the run base for the read-back pass.
                        bcnt_d   = 16'd0;
                        cur_d    = base_q;
                        araddr_d = base_q;
                        state_d  = StRdAddr;
                    end else begin
                        cur_d    = cur_q + BURST_INC;
                        awaddr_d = cur_q + BURST_INC;
                        state_d  = StWrAddr;
                    end
                end
            end
            StRdAddr: begin
                if (ARREADY) begin
                    beat_d  = 8'd0;
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (RVALID) begin
                    err_hit = (RRESP != 2'b00) || (RLAST != (beat_q == LEN_M1)) || rd_mismatch;
                    if (beat_q == LEN_M1) begin
                        bcnt_d = bcnt_q + 16'd1;
                        if ((bcnt_q + 16'd1) == num_q) begin
                            state_d = StFin;
                        end else begin
                            cur_d    = cur_q + BURST_INC;
                            araddr_d = cur_q + BURST_INC;
                            state_d  = StRdAddr;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (err_hit && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= StIdle;
            base_q    <= '0;
            cur_q     <= '0;
            num_q     <= '0;
            seed_q    <= '0;
            bcnt_q    <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            axlen_q   <= '0;
            axsize_q  <= '0;
            axburst_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cur_q     <= cur_d;
            num_q     <= num_d;
            seed_q    <= seed_d;
            bcnt_q    <= bcnt_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wlast_q   <= wlast_d;
            axlen_q   <= axlen_d;
            axsize_q  <= axsize_d;
            axburst_q <= axburst_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR_CNT = err_q;

    assign AWADDR  = awaddr_q;
    assign AWLEN   = axlen_q;
    assign AWSIZE  = axsize_q;
    assign AWBURST = axburst_q;
    assign AWVALID = (state_q == StWrAddr);

    assign WDATA   = wdata_q;
    assign WSTRB   = '1;
    assign WLAST   = wlast_q;
    assign WVALID  = (state_q == StWrData);

    assign BREADY  = (state_q == StWrResp);

    assign ARADDR  = araddr_q;
    assign ARLEN   = axlen_q;
    assign ARSIZE  = axsize_q;
    assign ARBURST = axburst_q;
    assign ARVALID = (state_q == StRdAddr);

    assign RREADY  = (state_q == StRdData);

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen: a memory-backed AXI slave with stall and error injection,
// and scoreboard queues of expected AW/AR addresses and write beats filled when each run starts.
module tb_axi_traffic_gen;

    localparam int BL = 16;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        START = 1'b0;
    logic [31:0] ADDR = '0;
    logic [15:0] NUM = '0;
    logic [31:0] SEED = '0;
    logic        BUSY, DONE;
    logic [15:0] ERR_CNT;
    logic [31:0] AWADDR, ARADDR, WDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic [3:0]  WSTRB;
    logic        AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0;
    logic        RVALID = 1'b0, RLAST = 1'b0;
    logic [1:0]  BRESP = '0, RRESP = '0;
    logic [31:0] RDATA = '0;

    axi_traffic_gen #(.WIDTH_AD(32), .WIDTH_DA(32), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .START(START), .ADDR(ADDR), .NUM(NUM), .SEED(SEED),
        .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic miss(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed unexpected event, expected none", tag);
    endtask

    logic [31:0] exp_aw[$], exp_ar[$], exp_w[$];
    logic [31:0] mem[logic [31:0]];

    bit          stall = 0;
    int          inj_bresp_burst = -1, inj_rresp_beat = -1, inj_rlast_beat = -1;
    logic [63:0] corrupt_mask = '0;
    int          w_idx = 0, wburst = 0, r_beats = 0, r_idx = 0, rbeat_g = 0;
    int          w_beats_total = 0, aw_cnt = 0, ar_cnt = 0;
    logic        b_pend = 0, r_taken = 0;
    logic [1:0]  b_resp = '0;
    logic [31:0] w_addr = '0, r_addr = '0;
    logic        aw_pend = 0, w_pend = 0, ar_pend = 0, wl_prev = 0;
    logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Slave: outputs change at negedge; handshakes for the next posedge are scored here too.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
            BRESP = 0; RRESP = 0;
            b_pend = 0; r_beats = 0; w_idx = 0; r_taken = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
        end else begin
            if (aw_pend) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_prev});
            if (w_pend)  chk("w_hold", {WVALID, WLAST, WDATA}, {1'b1, wl_prev, w_prev});
            if (ar_pend) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, ar_prev});

            AWREADY = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            WREADY  = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            ARREADY = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            BVALID  = b_pend;
            BRESP   = b_resp;
            if (r_beats > 0) begin
                if (!RVALID || r_taken) RVALID = stall ? 1'($urandom_range(1, 0)) : 1'b1;
                RDATA = rd_word(r_addr + 32'(r_idx * 4));
                if (rbeat_g < 64 && corrupt_mask[rbeat_g]) RDATA = RDATA ^ 32'h0000_0100;
                RRESP = (rbeat_g == inj_rresp_beat) ? 2'b11 : 2'b00;
                RLAST = (r_idx == BL - 1) ^ (rbeat_g == inj_rlast_beat);
            end else begin
                RVALID = 0;
            end
            r_taken = 0;

            if (AWVALID && AWREADY) begin
                aw_cnt++;
                if (exp_aw.size() == 0) miss("aw_extra");
                else chk("awaddr", AWADDR, exp_aw.pop_front());
                chk("aw_attr", {AWLEN, AWSIZE, AWBURST}, {8'd15, 3'd2, 2'b01});
                w_addr = AWADDR;
                w_idx  = 0;
            end
            if (WVALID && WREADY) begin
                if (exp_w.size() == 0) miss("w_extra");
                else chk("wdata", WDATA, exp_w.pop_front());
                chk("wlast", WLAST, w_idx == BL - 1);
                chk("wstrb", WSTRB, 4'hF);
                mem[w_addr + 32'(w_idx * 4)] = WDATA;
                if (w_idx == BL - 1) begin
                    b_pend = 1;
                    b_resp = (wburst == inj_bresp_burst) ? 2'b10 : 2'b00;
                end
                w_idx++;
                w_beats_total++;
            end
            if (BVALID && BREADY) begin
                b_pend = 0;
                wburst++;
            end
            if (ARVALID && ARREADY) begin
                ar_cnt++;
                if (exp_ar.size() == 0) miss("ar_extra");
                else chk("araddr", ARADDR, exp_ar.pop_front());
                chk("ar_attr", {ARLEN, ARSIZE, ARBURST}, {8'd15, 3'd2, 2'b01});
                r_addr  = ARADDR;
                r_beats = BL;
                r_idx   = 0;
            end
            if (RVALID && RREADY) begin
                r_idx++;
                r_beats--;
                rbeat_g++;
                r_taken = 1;
            end

            aw_pend = AWVALID && !AWREADY; aw_prev = AWADDR;
            w_pend  = WVALID && !WREADY;   w_prev  = WDATA;   wl_prev = WLAST;
            ar_pend = ARVALID && !ARREADY; ar_prev = ARADDR;
        end
    end

    task automatic start_run(input logic [31:0] a, input logic [15:0] n, input logic [31:0] s);
        for (int k = 0; k < int'(n); k++) begin
            exp_aw.push_back(a + 32'(k * BL * 4));
            exp_ar.push_back(a + 32'(k * BL * 4));
            for (int b = 0; b < BL; b++) exp_w.push_back((a + 32'(k * BL * 4 + b * 4)) ^ s);
        end
        wburst = 0; rbeat_g = 0; aw_cnt = 0; ar_cnt = 0; w_beats_total = 0;
        @(negedge ACLK); #1;
        ADDR = a; NUM = n; SEED = s; START = 1;
        @(negedge ACLK); #1;
        START = 0;
    endtask

    task automatic finish_run(input string tag, input int n, input logic [15:0] exp_err);
        int i;
        for (i = 0; i < 5000 && !DONE; i++) @(negedge ACLK);
        #1;
        if (!DONE) miss({tag, "_timeout"});
        chk({tag, "_done_busy"}, {DONE, BUSY}, 2'b10);
        chk({tag, "_err"}, ERR_CNT, exp_err);
        chk({tag, "_bursts"}, {16'(aw_cnt), 16'(ar_cnt)}, {16'(n), 16'(n)});
        chk({tag, "_left"}, exp_aw.size() + exp_ar.size() + exp_w.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_status", {BUSY, DONE, ERR_CNT}, 18'h0);
        chk("rst_valid", {AWVALID, WVALID, BREADY, ARVALID, RREADY, WLAST}, 6'h0);
        chk("rst_addr", {AWADDR, ARADDR}, 64'h0);
        chk("rst_wdata", WDATA, 32'h0);
        chk("rst_attr", {AWLEN, AWSIZE, AWBURST, ARLEN, ARSIZE, ARBURST}, 26'h0);
        ARESETn = 1;

        // Basic run, always-ready slave.
        start_run(32'h0000_1000, 16'd2, 32'h0);
        finish_run("basic", 2, 16'd0);

        // NUM == 0: no traffic, DONE two cycles after START.
        start_run(32'h0000_5000, 16'd0, 32'h0);
        chk("num0_c1", {AWVALID, WVALID, BREADY, ARVALID, RREADY, DONE, BUSY}, 7'b0000001);
        @(negedge ACLK); #1;
        chk("num0_c2", {AWVALID, WVALID, BREADY, ARVALID, RREADY, DONE, BUSY}, 7'b0000010);
        chk("num0_err", ERR_CNT, 16'd0);

        // Random stalls with a non-zero seed; a second START mid-run must be ignored.
        stall = 1;
        start_run(32'h0000_2000, 16'd3, 32'hA5A5_1234);
        repeat (10) @(negedge ACLK);
        #1;
        ADDR = 32'hDEAD_0000; NUM = 16'd5; SEED = 32'hFFFF_FFFF; START = 1;
        @(negedge ACLK); #1;
        START = 0;
        finish_run("stall", 3, 16'd0);
        stall = 0;

        // SLVERR on write burst 1 and DECERR on one read beat.
        inj_bresp_burst = 1; inj_rresp_beat = 5;
        start_run(32'h0000_4000, 16'd2, 32'h0000_00FF);
        finish_run("resp_err", 2, 16'd2);
        inj_bresp_burst = -1; inj_rresp_beat = -1;

        // Read-data corruption on three beats.
        corrupt_mask = (64'd1 << 3) | (64'd1 << 17) | (64'd1 << 30);
        start_run(32'h0000_6000, 16'd2, 32'h1357_9BDF);
`ifdef TGEN_CHECK_EN
        finish_run("corrupt", 2, 16'd3);
`else
        finish_run("corrupt", 2, 16'd0);
`endif
        corrupt_mask = '0;

        // Bad RRESP and bad RLAST on the same beat count once; a lone early RLAST counts once.
        inj_rresp_beat = 7; inj_rlast_beat = 7;
        start_run(32'h0000_7000, 16'd2, 32'h0);
        finish_run("one_per_beat", 2, 16'd1);
        inj_rlast_beat = 20;
        start_run(32'h0000_7000, 16'd2, 32'h0);
        finish_run("rlast_err", 2, 16'd2);
        inj_rresp_beat = -1; inj_rlast_beat = -1;

        // Address wraps past the top of the address space.
        start_run(32'hFFFF_FFC0, 16'd2, 32'h1234_5678);
        finish_run("wrap", 2, 16'd0);

        // Reset in the middle of a write burst.
        start_run(32'h0000_3000, 16'd2, 32'h0000_0055);
        for (int i = 0; i < 200 && !(WVALID && w_beats_total >= 5); i++) begin
            @(negedge ACLK); #1;
        end
        chk("mid_reached", {WVALID, 1'(w_beats_total >= 5)}, 2'b11);
        ARESETn = 0;
        #1;
        chk("mid_rst_status", {BUSY, DONE, ERR_CNT}, 18'h0);
        chk("mid_rst_valid", {AWVALID, WVALID, BREADY, ARVALID, RREADY, WLAST}, 6'h0);
        chk("mid_rst_addr", {AWADDR, ARADDR}, 64'h0);
        chk("mid_rst_wdata", WDATA, 32'h0);
        chk("mid_rst_attr", {AWLEN, AWSIZE, AWBURST, ARLEN, ARSIZE, ARBURST}, 26'h0);
        @(negedge ACLK); #1;
        chk("mid_rst_hold", {BUSY, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 6'h0);
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();
        @(negedge ACLK); #1;
        ARESETn = 1;
        repeat (5) @(negedge ACLK);
        #1;
        chk("no_resume", {BUSY, DONE, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 7'h0);
        start_run(32'h0000_8000, 16'd2, 32'h0BAD_F00D);
        finish_run("after_rst", 2, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
